// File: rtl/cia_pkg.sv
// rtl/cia_pkg.sv - shared constants and helpers for the CIA TOD counter
//
// Purpose : TCR bit positions, alarm reset pattern and byte-index helpers
//           used by cia_tod_counter and cia_tod_prescaler.
// Ports   : none (package).

package cia_pkg;

    // TCR bit 7 selects alarm (1) or TOD (0) as the target of byte writes.
    localparam int CIA_TCR_ALARM_BIT = 7;

    // Alarm powers up as all ones; sliced down to the configured width.
    localparam logic [31:0] CIA_ALARM_RESET = 32'hFFFF_FFFF;

    // Byte 0 is the low byte: writing it starts counting, reading it
    // releases the read latch.
    localparam int CIA_BYTE_LO = 0;

    // The top byte stops counting on write and freezes the latch on read.
    function automatic int cia_top_byte(input int bytes);
        return bytes - 1;
    endfunction

endpackage

// File: rtl/cia_tod_prescaler.sv
// rtl/cia_tod_prescaler.sv - programmable tick divider for the CIA TOD counter
//
// Purpose : divides the incoming tick strobe by prediv+1 and emits one inc
//           per completed period. Counter is held while counting is disabled
//           and cleared on every prediv write.
// Ports   :
//   clk        in   system clock
//   reset      in   synchronous, active-high, sampled only when clk7_en=1
//   clk7_en    in   clock enable
//   tick       in   count strobe, one clk7_en cycle wide
//   count_ena  in   counting enabled
//   prediv_wr  in   prediv is being written this cycle (clears pre_cnt)
//   prediv     in   divide ratio minus one
//   inc        out  combinational increment request for this cycle

module cia_tod_prescaler
    import cia_pkg::*;
#(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic             tick,
    input  logic             count_ena,
    input  logic             prediv_wr,
    input  logic [PRE_W-1:0] prediv,
    output logic             inc
);

    localparam logic [PRE_W-1:0] ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0] pre_cnt;
    logic             period_end;

    assign period_end = (pre_cnt == prediv);
    assign inc        = clk7_en && tick && count_ena && period_end;

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                pre_cnt <= '0;
            end else if (prediv_wr) begin
                pre_cnt <= '0;
            end else if (tick && count_ena) begin
                pre_cnt <= period_end ? '0 : pre_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/cia_tod_counter.sv
// rtl/cia_tod_counter.sv - parametrised CIA time-of-day counter with alarm irq
//
// Purpose : N-byte binary TOD counter with prescaled tick, read latch,
//           alarm compare and a two-cycle alarm irq pulse.
//           Build macro CIA_TOD_CARRY_BUG_EN: split the increment at bit
//           SPLIT with a one-cycle delayed carry into the upper part
//           (8520 transient mid-count glitch). Undefined: single
//           full-width increment.
// Ports   :
//   clk       in   system clock
//   reset     in   synchronous, active-high, sampled only when clk7_en=1
//   clk7_en   in   clock enable for all state
//   wr        in   1=write, 0=read of the selected register
//   sel       in   one-hot TOD/alarm byte select
//   tcr       in   control register select (bit7=ALARM, low bits=prediv)
//   data_in   in   write data
//   data_out  out  read data, 0 when nothing selected or wr=1
//   tick      in   count strobe
//   irq       out  alarm match request

module cia_tod_counter
    import cia_pkg::*;
#(
    parameter int BYTES = 3,
    parameter int PRE_W = 4,
    parameter int SPLIT = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic             wr,
    input  logic [BYTES-1:0] sel,
    input  logic             tcr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    input  logic             tick,
    output logic             irq
);

    localparam int             W         = BYTES * 8;
    localparam int             TOP       = cia_top_byte(BYTES);
    localparam logic [W-1:0]   ALARM_RST = CIA_ALARM_RESET[W-1:0];
    localparam logic [W-1:0]   ONE_W     = {{(W-1){1'b0}}, 1'b1};

    if (BYTES < 2 || BYTES > 4 || PRE_W < 1 || PRE_W > 7 ||
        SPLIT < 1 || SPLIT >= BYTES * 8) begin : g_bad_params
        $error("cia_tod_counter: parameter out of range");
    end

    logic [W-1:0]     tod;
    logic [W-1:0]     tod_next;
    logic [W-1:0]     alarm;
    logic [W-1:0]     tod_latch;
    logic [PRE_W-1:0] prediv;
    logic             alarm_sel;
    logic             count_ena;
    logic             latch_ena;
    logic             inc_d;
    logic             inc_d2;

    logic             inc;
    logic             inc_eff;
    logic             tod_wr;
    logic             alarm_wr;
    logic             tcr_wr;
    logic             rd_top;
    logic             rd_lo;

    // tcr takes the access when asserted; byte selects are ignored then.
    assign tcr_wr   = wr && tcr;
    assign tod_wr   = wr && !tcr && !alarm_sel && (|sel);
    assign alarm_wr = wr && !tcr &&  alarm_sel && (|sel);
    assign rd_top   = !wr && !tcr && !alarm_sel && sel[TOP];
    assign rd_lo    = !wr && !tcr && sel[CIA_BYTE_LO];

    // A TOD write in the same cycle as an increment wins; the increment is
    // dropped (the prescaler has still consumed its tick).
    assign inc_eff  = inc && !tod_wr;

    cia_tod_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clk7_en   (clk7_en),
        .tick      (tick),
        .count_ena (count_ena),
        .prediv_wr (tcr_wr),
        .prediv    (prediv),
        .inc       (inc)
    );

`ifdef CIA_TOD_CARRY_BUG_EN
    localparam logic [W-SPLIT-1:0] ONE_HI = {{(W-SPLIT-1){1'b0}}, 1'b1};
    localparam logic [SPLIT-1:0]   ONE_LO = {{(SPLIT-1){1'b0}}, 1'b1};

    // Carry out of the low field, applied to the high field one cycle late.
    logic carry_q;

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                carry_q <= 1'b0;
            end else begin
                carry_q <= inc_eff && (&tod[SPLIT-1:0]);
            end
        end
    end

    always_comb begin
        tod_next = tod;
        if (count_ena && carry_q) begin
            tod_next[W-1:SPLIT] = tod[W-1:SPLIT] + ONE_HI;
        end
        if (inc_eff) begin
            tod_next[SPLIT-1:0] = tod[SPLIT-1:0] + ONE_LO;
        end
        if (tod_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (sel[i]) begin
                    tod_next[8*i +: 8] = data_in;
                end
            end
        end
    end
`else
    always_comb begin
        tod_next = tod;
        if (inc_eff) begin
            tod_next = tod + ONE_W;
        end
        if (tod_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (sel[i]) begin
                    tod_next[8*i +: 8] = data_in;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                tod       <= '0;
                alarm     <= ALARM_RST;
                tod_latch <= '0;
                prediv    <= '0;
                alarm_sel <= 1'b0;
                count_ena <= 1'b0;
                latch_ena <= 1'b1;
                inc_d     <= 1'b0;
                inc_d2    <= 1'b0;
            end else begin
                tod <= tod_next;

                if (alarm_wr) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (sel[i]) begin
                            alarm[8*i +: 8] <= data_in;
                        end
                    end
                end

                if (tcr_wr) begin
                    alarm_sel <= data_in[CIA_TCR_ALARM_BIT];
                    prediv    <= data_in[PRE_W-1:0];
                end

                // Top byte write stops the clock, byte 0 (or a tcr write with
                // ALARM=0) restarts it; byte 0 has the last word.
                if (tod_wr && sel[TOP]) begin
                    count_ena <= 1'b0;
                end
                if ((tod_wr && sel[CIA_BYTE_LO]) ||
                    (tcr_wr && !data_in[CIA_TCR_ALARM_BIT])) begin
                    count_ena <= 1'b1;
                end

                // The latch still captures on the edge of the freezing read,
                // so the frozen value is the TOD at the time of that read.
                if (latch_ena) begin
                    tod_latch <= tod;
                end
                if (rd_top) begin
                    latch_ena <= 1'b0;
                end
                if (rd_lo) begin
                    latch_ena <= 1'b1;
                end

                // A TOD load flushes the pipe so a loaded match cannot fire.
                inc_d  <= inc_eff;
                inc_d2 <= tod_wr ? 1'b0 : inc_d;
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (!wr) begin
            if (tcr) begin
                data_out[CIA_TCR_ALARM_BIT] = alarm_sel;
                data_out[PRE_W-1:0]         = prediv;
            end else begin
                for (int i = 0; i < BYTES; i++) begin
                    if (sel[i]) begin
                        data_out = data_out | tod_latch[8*i +: 8];
                    end
                end
            end
        end
    end

    assign irq = (tod == alarm) && (inc_d || inc_d2);

endmodule

// File: tb/tb_cia_tod_counter.sv
// tb/tb_cia_tod_counter.sv - self-checking bench for cia_tod_counter

module tb_cia_tod_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk7_en = 1'b1;
    logic        wr = 1'b0;
    logic [2:0]  sel = '0;
    logic        tcr = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        tick = 1'b0;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got;
    logic [23:0] exp;
    logic [7:0]  b;

    cia_tod_counter #(
        .BYTES(3),
        .PRE_W(4),
        .SPLIT(12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .wr       (wr),
        .sel      (sel),
        .tcr      (tcr),
        .data_in  (data_in),
        .data_out (data_out),
        .tick     (tick),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] s, input logic t, input logic [7:0] d);
        wr = 1'b1; sel = s; tcr = t; data_in = d;
        step();
        wr = 1'b0; sel = '0; tcr = 1'b0; data_in = '0;
    endtask

    task automatic do_read(input logic [2:0] s, input logic t, output logic [7:0] d);
        wr = 1'b0; sel = s; tcr = t;
        #1;
        d = data_out;
        step();
        sel = '0; tcr = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic write_tod(input logic [23:0] v);
        do_write(3'b100, 1'b0, v[23:16]);
        do_write(3'b010, 1'b0, v[15:8]);
        do_write(3'b001, 1'b0, v[7:0]);
    endtask

    task automatic read_tod(output logic [23:0] v);
        logic [7:0] b2, b1, b0;
        step();
        step();
        do_read(3'b100, 1'b0, b2);
        do_read(3'b010, 1'b0, b1);
        do_read(3'b001, 1'b0, b0);
        v = {b2, b1, b0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        exp_q.push_back(24'h0);
        got = {23'h0, irq};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_irq got=%h exp=%h", got, exp); end

        exp_q.push_back(24'h0);
        do_read(3'b000, 1'b1, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_tcr got=%h exp=%h", got, exp); end

        exp_q.push_back(24'h0);
        do_read(3'b000, 1'b0, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL nosel_data got=%h exp=%h", got, exp); end

        repeat (5) do_tick();
        exp_q.push_back(24'h000000);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL no_count_before_start got=%h exp=%h", got, exp); end

        // data_out stays zero during a write
        exp_q.push_back(24'h0);
        wr = 1'b1; sel = 3'b001; data_in = 8'h00;
        #1;
        got = {16'h0, data_out};
        step();
        wr = 1'b0; sel = '0;
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL wr_data_zero got=%h exp=%h", got, exp); end

        do_tick();
        exp_q.push_back(24'h000001);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL count_after_start got=%h exp=%h", got, exp); end
    endtask

    task automatic test_prescaler();
        do_write(3'b000, 1'b1, 8'h02);
        write_tod(24'h000000);
        repeat (6) do_tick();
        exp_q.push_back(24'h000002);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL prescale_div3 got=%h exp=%h", got, exp); end

        exp_q.push_back(24'h000002);
        do_read(3'b000, 1'b1, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL tcr_readback got=%h exp=%h", got, exp); end
    endtask

    task automatic test_latch();
        do_write(3'b000, 1'b1, 8'h00);
        write_tod(24'h00FFFF);
        step();
        step();
        exp_q.push_back(24'h00);
        do_read(3'b100, 1'b0, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL latch_top got=%h exp=%h", got, exp); end

        repeat (3) do_tick();
        exp_q.push_back(24'hFF);
        exp_q.push_back(24'hFF);
        do_read(3'b010, 1'b0, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL latch_byte1 got=%h exp=%h", got, exp); end
        do_read(3'b001, 1'b0, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL latch_byte0 got=%h exp=%h", got, exp); end

        exp_q.push_back(24'h010002);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL latch_released got=%h exp=%h", got, exp); end
    endtask

    task automatic test_alarm();
        do_write(3'b000, 1'b1, 8'h80);
        exp_q.push_back(24'h80);
        do_read(3'b000, 1'b1, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL tcr_alarm_sel got=%h exp=%h", got, exp); end

        do_write(3'b100, 1'b0, 8'h00);
        do_write(3'b010, 1'b0, 8'h00);
        do_write(3'b001, 1'b0, 8'h10);
        do_write(3'b000, 1'b1, 8'h00);

        // loading the alarm value directly must stay quiet
        write_tod(24'h000010);
        repeat (3) exp_q.push_back(24'h0);
        for (int i = 0; i < 3; i++) begin
            got = {23'h0, irq};
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL irq_on_load cyc=%0d got=%h exp=%h", i, got, exp); end
            step();
        end

        write_tod(24'h00000F);
        step();
        do_tick();
        exp_q.push_back(24'h1);
        exp_q.push_back(24'h1);
        exp_q.push_back(24'h0);
        exp_q.push_back(24'h0);
        for (int i = 0; i < 4; i++) begin
            got = {23'h0, irq};
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL irq_pulse cyc=%0d got=%h exp=%h", i, got, exp); end
            step();
        end
    endtask

    task automatic test_carry();
        write_tod(24'h000FFF);
        do_tick();
`ifdef CIA_TOD_CARRY_BUG_EN
        exp_q.push_back(24'h000000);
`else
        exp_q.push_back(24'h001000);
`endif
        exp_q.push_back(24'h001000);
        for (int i = 0; i < 2; i++) begin
            got = dut.tod;
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL carry cyc=%0d got=%h exp=%h", i, got, exp); end
            step();
        end

        write_tod(24'hFFFFFF);
        do_tick();
        exp_q.push_back(24'h000000);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL wrap got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        write_tod(24'h000005);
        wr = 1'b1; sel = 3'b100; data_in = 8'h22; tick = 1'b1;
        step();
        wr = 1'b0; sel = '0; data_in = '0; tick = 1'b0;
        do_tick();
        do_tick();
        exp_q.push_back(24'h220005);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL write_beats_inc got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid();
        write_tod(24'h000123);
        do_tick();
        // reset without clock enable must be ignored
        clk7_en = 1'b0; reset = 1'b1;
        step();
        clk7_en = 1'b1; reset = 1'b0;
        exp_q.push_back(24'h000124);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_gated got=%h exp=%h", got, exp); end

        do_write(3'b000, 1'b1, 8'h85);
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_tick();
        exp_q.push_back(24'h000000);
        read_tod(got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_mid_tod got=%h exp=%h", got, exp); end

        exp_q.push_back(24'h0);
        do_read(3'b000, 1'b1, b);
        got = {16'h0, b};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_mid_tcr got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_latch();
        test_alarm();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
